stored_value_decryptor: RTL and testbench

// - Downstream consumer of the encryptor memory: reads one stored 8-bit product, divides it by the key, and rotates the quotient left by ROT.
// - Recovers the original 4-bit Num; flags products that cannot be a valid encryption (key 0, non-zero remainder, quotient overflow).
// - Sequential restoring divider, one quotient bit per clock; valid/ready output handshake.

---
 rtl/stored_value_decryptor.sv | 200 ++++++++++++++++++++
 tb/tb_stored_value_decryptor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stored_value_decryptor.sv
// stored_value_decryptor
//   Reads one stored product from the encryptor memory, divides it by the key
//   with a sequential restoring divider (one quotient bit per clock), and
//   rotates the quotient left by ROT to recover the original number.
//   Products that cannot be a valid encryption are flagged with out_err:
//   key of zero, non-zero remainder, or a quotient that does not fit DATA_W.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         request a decrypt (sampled only while idle)
//   addr, key     memory entry and decryption key, latched with start
//   rd_sel        one-hot memory read select, entry n -> bit DEPTH-1-n
//   rd_data       memory read data (combinational from rd_sel)
//   busy          high whenever not idle
//   out_valid     result valid, held until out_ready
//   out_ready     consumer accepts the result
//   out_num       recovered number (0 when out_err)
//   out_err       result is not a valid encryption
//   err_count     (only with DEC_ERRCNT_EN defined) saturating count of
//                 accepted results that carried out_err
//
// Build option: define DEC_ERRCNT_EN to add the err_count output.

module stored_value_decryptor #(
  parameter int DATA_W = 4,
  parameter int PROD_W = 8,
  parameter int ROT    = 2,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        key,
  output logic [DEPTH-1:0]         rd_sel,
  input  logic [PROD_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_num,
  output logic                     out_err
`ifdef DEC_ERRCNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(PROD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(PROD_W - 1);
  localparam logic [DEPTH-1:0]  SEL_MSB   = {1'b1, {(DEPTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DIVIDE, S_DONE} state_e;

  // Left rotate by ROT; written as a bit loop so ROT==0 degenerates cleanly.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[(i + ROT) % DATA_W] = v[i];
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [PROD_W-1:0]   div_q, div_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [PROD_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_num_q, out_num_d;
  logic                out_err_q, out_err_d;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the key when it fits. The extra top bit keeps the shifted
  // remainder exact before the compare.
  logic [DATA_W+1:0]   rem_sh;
  logic [DATA_W+1:0]   key_ext;
  logic                q_bit;
  logic [DATA_W:0]     rem_next;
  logic [PROD_W-1:0]   quo_next;
  logic                bad_result;

  always_comb begin
    rem_sh     = {rem_q, div_q[PROD_W-1]};
    key_ext    = {2'b00, key_q};
    q_bit      = (rem_sh >= key_ext);
    rem_next   = q_bit ? (DATA_W+1)'(rem_sh - key_ext) : (DATA_W+1)'(rem_sh);
    quo_next   = PROD_W'({quo_q, q_bit});
    bad_result = (rem_next != '0) || (quo_next[PROD_W-1:DATA_W] != '0);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    key_d       = key_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    out_err_d   = out_err_q;
    rd_sel      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          key_d   = key;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_sel = SEL_MSB >> addr_q;
        if (key_q == '0) begin
          // Division by zero is reported right away without dividing.
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_num_d   = '0;
          state_d     = S_DONE;
        end else begin
          div_d   = rd_data;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        div_d = div_q << 1;
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          out_valid_d = 1'b1;
          out_err_d   = bad_result;
          out_num_d   = bad_result ? '0 : rotl(quo_next[DATA_W-1:0]);
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      key_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      key_q       <= key_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_err_q   <= out_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_err   = out_err_q;

`ifdef DEC_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counts only results the consumer actually took; sticks at 8'hFF.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q == S_DONE) && out_ready && out_err_q && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_stored_value_decryptor.sv
module tb_stored_value_decryptor;

  localparam int DATA_W = 4;
  localparam int PROD_W = 8;
  localparam int ROT    = 2;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [3:0]        addr;
  logic [DATA_W-1:0] key;
  logic [DEPTH-1:0]  rd_sel;
  logic [PROD_W-1:0] rd_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_num;
  logic              out_err;
`ifdef DEC_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  logic [7:0] mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  stored_value_decryptor #(
    .DATA_W(DATA_W), .PROD_W(PROD_W), .ROT(ROT), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .addr     (addr),
    .key      (key),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_num  (out_num),
    .out_err  (out_err)
`ifdef DEC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // Memory: entry n answers on select bit DEPTH-1-n.
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < DEPTH; n++)
      if (rd_sel[DEPTH-1-n]) rd_data = mem[n];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer divide, validate, then rotate left by two.
  function automatic void model(input int prod, input int k, output logic [3:0] num, output logic err);
    if (k == 0) begin
      err = 1'b1;
      num = 4'd0;
    end else begin
      int q;
      int r;
      q   = prod / k;
      r   = prod % k;
      err = (r != 0) || (q > 15);
      num = err ? 4'd0 : 4'(((q << ROT) | (q >> (DATA_W - ROT))) & 15);
    end
  endfunction

  task automatic do_op(input int a, input int k, input int p, input int hold, input bit start_at_hs);
    logic [3:0] en;
    logic       ee;
    int         cyc;
    mem[a] = 8'(p);
    model(p, k, en, ee);
    addr  = 4'(a);
    key   = 4'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_fetch", {31'd0, busy}, 32'd1);
    check_val("rd_sel", {16'd0, rd_sel}, 32'h8000 >> a);
    // Inputs are latched; scramble them to prove it.
    addr = 4'($urandom);
    key  = 4'($urandom);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("latency", cyc, (k == 0) ? 32'd1 : 32'd9);
    check_val("out_num", {28'd0, out_num}, {28'd0, en});
    check_val("out_err", {31'd0, out_err}, {31'd0, ee});
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(posedge clk); #1;
      check_val("hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_num", {28'd0, out_num}, {28'd0, en});
      check_val("hold_err", {31'd0, out_err}, {31'd0, ee});
    end
    start     = start_at_hs;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check_val("hs_valid", {31'd0, out_valid}, 32'd0);
    check_val("hs_busy", {31'd0, busy}, 32'd0);
    if (ee && exp_errcnt < 255) exp_errcnt++;
    @(posedge clk); #1;
    check_val("idle_busy", {31'd0, busy}, 32'd0);
`ifdef DEC_ERRCNT_EN
    check_val("err_count", {24'd0, err_count}, exp_errcnt);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    addr      = '0;
    key       = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    #12;
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_rd_sel", {16'd0, rd_sel}, 32'd0);
    check_val("rst_num", {28'd0, out_num}, 32'd0);
    check_val("rst_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(0, 8, 8'h10, 0, 1'b0);
    do_op(1, 8, 8'h30, 1, 1'b0);
    do_op(2, 10, 8'h1E, 0, 1'b1);
    do_op(5, 14, 8'hC4, 2, 1'b0);
    do_op(7, 0, 8'h55, 0, 1'b0);
    do_op(9, 8, 8'h11, 0, 1'b0);
    do_op(15, 1, 8'hFF, 0, 1'b0);
    do_op(3, 3, 8'h2D, 5, 1'b1);

    // Reset in the middle of a divide.
    mem[4] = 8'h30;
    addr   = 4'd4;
    key    = 4'd8;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_rd_sel", {16'd0, rd_sel}, 32'd0);
    check_val("mid_rst_num", {28'd0, out_num}, 32'd0);
    check_val("mid_rst_err", {31'd0, out_err}, 32'd0);
    #2 rst_n = 1'b1;
    exp_errcnt = 0;
    @(posedge clk); #1;
    do_op(4, 8, 8'h30, 0, 1'b0);

    // Randomized transactions, half built from a valid encryption.
    for (int t = 0; t < 40; t++) begin
      int a;
      int k;
      int n;
      int p;
      a = $urandom_range(0, DEPTH - 1);
      k = $urandom_range(0, 15);
      n = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) p = k * (((n >> ROT) | (n << (DATA_W - ROT))) & 15);
      else                           p = $urandom_range(0, 255);
      do_op(a, k, p, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

`ifdef DEC_ERRCNT_EN
    for (int t = 0; t < 300; t++) do_op(t % DEPTH, 0, 8'h00, 0, 1'b0);
    check_val("err_count_sat", {24'd0, err_count}, 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
